// File: rtl/spi_pwm_cfg_ctrl_pkg.sv
// spi_pwm_cfg_pkg: shared constants and FSM state type for the SPI PWM
// configuration controller. Optional readback is enabled by the macro
// SPI_PWM_CFG_READBACK_EN (see spi_pwm_cfg_ctrl.sv).
package spi_pwm_cfg_pkg;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;

   localparam int FRAME_BITS = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/spi_pwm_cfg_ctrl_if.sv
// SPI pin bundle. The bus controller drives sclk/copi/ncs and samples cipo;
// the configuration target does the opposite.
interface spi_pwm_cfg_if;

   logic sclk_in;
   logic copi_in;
   logic ncs_in;
   logic cipo_out;

   modport master (output sclk_in, output copi_in, output ncs_in, input cipo_out);
   modport slave  (input sclk_in, input copi_in, input ncs_in, output cipo_out);

endinterface

// File: rtl/spi_pwm_cfg_ctrl_sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for one asynchronous pin followed by
// a single-flop edge detector. All edge outputs derive from synced values.
module sync_edge_det #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Synchronizer chain plus the history flop used for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain <= {SYNC_STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// spi_pwm_cfg_ctrl: SPI mode-0 target that writes the five PWM configuration
// registers from 16-bit frames {rw, addr[6:0], data[7:0]}, MSB first.
// Define SPI_PWM_CFG_READBACK_EN to return register contents on cipo_out
// during read frames; otherwise cipo_out is tied low.
//
// Pins arrive asynchronously through spi.slave; sclk/copi/ncs are each
// synchronized and edge-detected before the FSM sees them. The FSM state is
// exported on state_dbg.
module spi_pwm_cfg_ctrl
   import spi_pwm_cfg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_pwm_cfg_if.slave       spi,
   output logic [7:0]         en_reg_out_7_0,
   output logic [7:0]         en_reg_out_15_8,
   output logic [7:0]         en_reg_pwm_7_0,
   output logic [7:0]         en_reg_pwm_15_8,
   output logic [7:0]         pwm_duty_cycle,
   output logic               frame_err,
   output state_t             state_dbg
);

   localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic copi_lvl, copi_rise, copi_fall;
   logic ncs_lvl,  ncs_rise,  ncs_fall;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .din(spi.sclk_in),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
      .clk(clk), .rst_n(rst_n), .din(spi.copi_in),
      .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
      .clk(clk), .rst_n(rst_n), .din(spi.ncs_in),
      .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

   // Only levels/edges the FSM needs are consumed; fold the rest here.
   logic unused_edges;
   assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

   state_t      state;
   logic [15:0] shreg;
   logic [4:0]  cnt;
   logic        fall_held;   // nCS fell while in COMMIT; IDLE picks it up
   logic [7:0]  tx;          // readback shifter, MSB drives cipo

   // Address formed by the 8th SCLK rising edge: shreg[5:0] plus current bit.
   logic [6:0]  rd_addr;
   logic [7:0]  rd_data;
   assign rd_addr = {shreg[5:0], copi_lvl};

   // Register mux for readback; unmapped addresses return zero.
   always_comb begin
      rd_data = 8'h00;
      case (rd_addr)
         ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
         ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
         ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
         ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
         ADDR_DUTY:      rd_data = pwm_duty_cycle;
         default:        rd_data = 8'h00;
      endcase
   end

   // Frame FSM: collect bits while nCS is low, then commit or reject.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         shreg           <= '0;
         cnt             <= '0;
         fall_held       <= 1'b0;
         tx              <= '0;
         frame_err       <= 1'b0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               tx        <= '0;
               fall_held <= 1'b0;
               if (ncs_fall || (fall_held && !ncs_lvl)) begin
                  shreg <= '0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // An SCLK edge coinciding with nCS rising is dropped.
               if (ncs_rise) begin
                  state <= COMMIT;
               end else if (sclk_rise) begin
                  shreg <= {shreg[14:0], copi_lvl};
                  if (cnt != 5'd17) cnt <= cnt + 5'd1;
`ifdef SPI_PWM_CFG_READBACK_EN
                  if (cnt == 5'd7 && !shreg[6] && rd_addr <= MAX_A)
                     tx <= rd_data;
`endif
               end
`ifdef SPI_PWM_CFG_READBACK_EN
               // The fall right after the 8th rise keeps the MSB on the pin
               // so the controller samples it on the 9th rise.
               else if (sclk_fall && cnt > 5'd8) begin
                  tx <= {tx[6:0], 1'b0};
               end
`endif
            end
            COMMIT: begin
               if (cnt == 5'd16 && shreg[14:8] <= MAX_A) begin
                  if (shreg[15]) begin
                     case (shreg[14:8])
                        ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
                        ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
                        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
                        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
                        ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
                        default: ;
                     endcase
                  end
               end else begin
                  frame_err <= 1'b1;
               end
               fall_held <= ncs_fall;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_PWM_CFG_READBACK_EN
   assign spi.cipo_out = tx[7];
`else
   assign spi.cipo_out = 1'b0;
   logic unused_tx;
   assign unused_tx = ^{tx, rd_data};
`endif

   assign state_dbg = state;

endmodule
